// File: rtl/sa_pkg.sv
// sa_pkg: shared widths and lane slicing helpers for the systolic array
// multiplier datapath.
package sa_pkg;

  localparam int SA_MAG_W  = 7;
  localparam int SA_PROD_W = 2 * SA_MAG_W;

  // Bit offset of a lane inside a flat vector of w-bit lanes.
  function automatic int lane_off(input int lane, input int w);
    return lane * w;
  endfunction

  // Bit offset of a lane inside the flat product vector (2*mag_w bits per lane).
  function automatic int prod_off(input int lane, input int mag_w);
    return lane * 2 * mag_w;
  endfunction

endpackage

// File: rtl/sm_mult_lane.sv
// sm_mult_lane: combinational sign-magnitude product for one lane.
// The sign arrives already XORed (and lane-enable masked) from the entry stage.
// Build option SM_NEG_ZERO_CLR_EN: a zero product always reports sign 0.
module sm_mult_lane
  import sa_pkg::*;
#(
  parameter int MAG_W = SA_MAG_W
) (
  input  logic                 sign_in,
  input  logic [MAG_W-1:0]     a_mag,
  input  logic [MAG_W-1:0]     b_mag,
  output logic                 p_sign,
  output logic [2*MAG_W-1:0]   p_mag
);

  localparam int PROD_W = 2 * MAG_W;

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;

  // Full-width unsigned product; sign is optionally forced positive on zero.
  always_comb begin
    a_ext = {{MAG_W{1'b0}}, a_mag};
    b_ext = {{MAG_W{1'b0}}, b_mag};
    p_mag = a_ext * b_ext;
`ifdef SM_NEG_ZERO_CLR_EN
    p_sign = sign_in && (p_mag != '0);
`else
    p_sign = sign_in;
`endif
  end

endmodule

// File: rtl/sm_mult_pipe.sv
// sm_mult_pipe: multi-lane pipelined sign-magnitude multiplier with a
// valid/ready handshake. Stage 1 captures the masked sign XOR and both
// magnitudes, middle stages are plain delay, and the final stage registers
// the product. All stages advance together whenever the output is not held.
// Build option SM_NEG_ZERO_CLR_EN: zero-magnitude products never carry sign 1.
module sm_mult_pipe
  import sa_pkg::*;
#(
  parameter int MAG_W  = SA_MAG_W,
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          lane_en,
  input  logic [LANES-1:0]          a_sign,
  input  logic [LANES*MAG_W-1:0]    a_mag,
  input  logic [LANES-1:0]          b_sign,
  input  logic [LANES*MAG_W-1:0]    b_mag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          p_sign,
  output logic [LANES*2*MAG_W-1:0]  p_mag
);

  localparam int PROD_W = 2 * MAG_W;
  localparam int MID_N  = (STAGES > 1) ? STAGES - 1 : 1;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("sm_mult_pipe: STAGES must be in 1..4");
  end

  logic                     adv;
  logic                     accept;

  logic [LANES-1:0]         ent_sign;
  logic [LANES*MAG_W-1:0]   ent_amag;
  logic [LANES*MAG_W-1:0]   ent_bmag;

  logic                     feed_vld;
  logic [LANES-1:0]         feed_sign;
  logic [LANES*MAG_W-1:0]   feed_amag;
  logic [LANES*MAG_W-1:0]   feed_bmag;

  logic [LANES-1:0]         lane_sign;
  logic [LANES*PROD_W-1:0]  lane_mag;

  logic                     out_valid_q, out_valid_d;
  logic [LANES-1:0]         p_sign_q, p_sign_d;
  logic [LANES*PROD_W-1:0]  p_mag_q, p_mag_d;

  // Global advance: everything moves unless a presented result is being held.
  always_comb begin
    adv    = !out_valid_q || out_ready;
    accept = in_valid && adv;
  end

  assign in_ready = adv;

  // Entry conditioning: disabled lanes carry sign 0 and zero magnitudes so
  // their product comes out as +0 without any special case downstream.
  always_comb begin
    ent_sign = '0;
    ent_amag = '0;
    ent_bmag = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        ent_sign[i] = a_sign[i] ^ b_sign[i];
        ent_amag[lane_off(i, MAG_W) +: MAG_W] = a_mag[lane_off(i, MAG_W) +: MAG_W];
        ent_bmag[lane_off(i, MAG_W) +: MAG_W] = b_mag[lane_off(i, MAG_W) +: MAG_W];
      end
    end
  end

  if (STAGES > 1) begin : g_mid
    logic [MID_N-1:0]                    vld_q, vld_d;
    logic [MID_N-1:0][LANES-1:0]         sign_q, sign_d;
    logic [MID_N-1:0][LANES*MAG_W-1:0]   amag_q, amag_d;
    logic [MID_N-1:0][LANES*MAG_W-1:0]   bmag_q, bmag_d;

    // Delay line: entry slot captures an accepted bundle (bubble otherwise),
    // later slots copy forward; data only moves alongside a valid bundle.
    always_comb begin
      vld_d  = vld_q;
      sign_d = sign_q;
      amag_d = amag_q;
      bmag_d = bmag_q;
      if (adv) begin
        vld_d[0] = accept;
        if (accept) begin
          sign_d[0] = ent_sign;
          amag_d[0] = ent_amag;
          bmag_d[0] = ent_bmag;
        end
        for (int k = 1; k < MID_N; k++) begin
          vld_d[k] = vld_q[k-1];
          if (vld_q[k-1]) begin
            sign_d[k] = sign_q[k-1];
            amag_d[k] = amag_q[k-1];
            bmag_d[k] = bmag_q[k-1];
          end
        end
      end
    end

    // Stage registers; reset drops every in-flight bundle.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q  <= '0;
        sign_q <= '0;
        amag_q <= '0;
        bmag_q <= '0;
      end else begin
        vld_q  <= vld_d;
        sign_q <= sign_d;
        amag_q <= amag_d;
        bmag_q <= bmag_d;
      end
    end

    assign feed_vld  = vld_q[MID_N-1];
    assign feed_sign = sign_q[MID_N-1];
    assign feed_amag = amag_q[MID_N-1];
    assign feed_bmag = bmag_q[MID_N-1];
  end else begin : g_direct
    // Single-stage build: the final register multiplies straight off the inputs.
    assign feed_vld  = accept;
    assign feed_sign = ent_sign;
    assign feed_amag = ent_amag;
    assign feed_bmag = ent_bmag;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sm_mult_lane #(
      .MAG_W (MAG_W)
    ) u_lane (
      .sign_in (feed_sign[g]),
      .a_mag   (feed_amag[lane_off(g, MAG_W) +: MAG_W]),
      .b_mag   (feed_bmag[lane_off(g, MAG_W) +: MAG_W]),
      .p_sign  (lane_sign[g]),
      .p_mag   (lane_mag[prod_off(g, MAG_W) +: PROD_W])
    );
  end

  // Final stage: load products on advance; bubbles leave the data untouched.
  always_comb begin
    out_valid_d = out_valid_q;
    p_sign_d    = p_sign_q;
    p_mag_d     = p_mag_q;
    if (adv) begin
      out_valid_d = feed_vld;
      if (feed_vld) begin
        p_sign_d = lane_sign;
        p_mag_d  = lane_mag;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      p_sign_q    <= '0;
      p_mag_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      p_sign_q    <= p_sign_d;
      p_mag_q     <= p_mag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p_sign    = p_sign_q;
  assign p_mag     = p_mag_q;

endmodule

// File: tb/tb_sm_mult_pipe.sv
// tb_sm_mult_pipe: directed self-checking bench for sm_mult_pipe with
// MAG_W=7, LANES=4, STAGES=2.
module tb_sm_mult_pipe;

  localparam int MAG_W  = 7;
  localparam int LANES  = 4;
  localparam int STAGES = 2;

`ifdef SM_NEG_ZERO_CLR_EN
  localparam logic NZ_SIGN = 1'b0;
`else
  localparam logic NZ_SIGN = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  lane_en = 4'h0;
  logic [3:0]  a_sign = 4'h0;
  logic [27:0] a_mag = '0;
  logic [3:0]  b_sign = 4'h0;
  logic [27:0] b_mag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  p_sign;
  logic [55:0] p_mag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sm_mult_pipe #(
    .MAG_W  (MAG_W),
    .LANES  (LANES),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lane_en   (lane_en),
    .a_sign    (a_sign),
    .a_mag     (a_mag),
    .b_sign    (b_sign),
    .b_mag     (b_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_sign    (p_sign),
    .p_mag     (p_mag)
  );

  function automatic logic [27:0] pk_a(input int m3, input int m2, input int m1, input int m0);
    return {7'(m3), 7'(m2), 7'(m1), 7'(m0)};
  endfunction

  function automatic logic [55:0] pk_p(input int m3, input int m2, input int m1, input int m0);
    return {14'(m3), 14'(m2), 14'(m1), 14'(m0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] as, input logic [27:0] am,
                       input logic [3:0] bs, input logic [27:0] bm);
    in_valid = 1'b1;
    lane_en  = en;
    a_sign   = as;
    a_mag    = am;
    b_sign   = bs;
    b_mag    = bm;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (p_sign !== 4'h0) begin n_err++; $display("FAIL reset_sign: got %h want 0", p_sign); end
    n_cmp++; if (p_mag !== 56'h0) begin n_err++; $display("FAIL reset_mag: got %h want 0", p_mag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    reset = 1'b0;
  endtask

  // Lane0 (-5)*(+3), lane1 (-0)*(+9), lane2 (-127)*(-127), lane3 (+2)*(+4).
  // Driven in the same cycle reset is released: accepted on the first edge.
  task automatic test_basic();
    drive(4'hF, 4'b0111, pk_a(2, 127, 0, 5), 4'b0100, pk_a(4, 127, 9, 3));
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early: got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (p_sign !== {1'b0, 1'b0, NZ_SIGN, 1'b1}) begin
      n_err++; $display("FAIL basic_sign: got %b want %b", p_sign, {1'b0, 1'b0, NZ_SIGN, 1'b1});
    end
    n_cmp++; if (p_mag !== pk_p(8, 16129, 0, 15)) begin
      n_err++; $display("FAIL basic_mag: got %h want %h", p_mag, pk_p(8, 16129, 0, 15));
    end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_bubble_valid: got %b want 0", out_valid); end
    n_cmp++; if (p_mag !== pk_p(8, 16129, 0, 15)) begin
      n_err++; $display("FAIL basic_bubble_hold: got %h want %h", p_mag, pk_p(8, 16129, 0, 15));
    end
  endtask

  task automatic test_lane_en();
    drive(4'b0101, 4'b0000, pk_a(10, 10, 10, 10), 4'b1111, pk_a(10, 10, 10, 10));
    step();
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lane_en_valid: got %b want 1", out_valid); end
    n_cmp++; if (p_sign !== 4'b0101) begin n_err++; $display("FAIL lane_en_sign: got %b want 0101", p_sign); end
    n_cmp++; if (p_mag !== pk_p(0, 100, 0, 100)) begin
      n_err++; $display("FAIL lane_en_mag: got %h want %h", p_mag, pk_p(0, 100, 0, 100));
    end
    step();
  endtask

  // Back-to-back with a bubble inserted; out_ready held high throughout.
  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(4'hF, 4'h0, pk_a(1, 1, 1, 1), 4'h0, pk_a(1, 1, 1, 1));
    step();
    drive(4'hF, 4'h0, pk_a(2, 2, 2, 2), 4'h0, pk_a(2, 2, 2, 2));
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_t1_valid: got %b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_t2_valid: got %b want 1", out_valid); end
    n_cmp++; if (p_mag !== pk_p(1, 1, 1, 1)) begin n_err++; $display("FAIL b2b_t2_mag: got %h want %h", p_mag, pk_p(1, 1, 1, 1)); end
    n_cmp++; if (p_sign !== 4'h0) begin n_err++; $display("FAIL b2b_t2_sign: got %b want 0000", p_sign); end
    step();
    drive(4'hF, 4'hF, pk_a(3, 3, 3, 3), 4'h0, pk_a(3, 3, 3, 3));
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_t3_valid: got %b want 1", out_valid); end
    n_cmp++; if (p_mag !== pk_p(4, 4, 4, 4)) begin n_err++; $display("FAIL b2b_t3_mag: got %h want %h", p_mag, pk_p(4, 4, 4, 4)); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_t4_bubble: got %b want 0", out_valid); end
    n_cmp++; if (p_mag !== pk_p(4, 4, 4, 4)) begin n_err++; $display("FAIL b2b_t4_hold: got %h want %h", p_mag, pk_p(4, 4, 4, 4)); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_t5_valid: got %b want 1", out_valid); end
    n_cmp++; if (p_mag !== pk_p(9, 9, 9, 9)) begin n_err++; $display("FAIL b2b_t5_mag: got %h want %h", p_mag, pk_p(9, 9, 9, 9)); end
    n_cmp++; if (p_sign !== 4'hF) begin n_err++; $display("FAIL b2b_t5_sign: got %b want 1111", p_sign); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_t6_valid: got %b want 0", out_valid); end
  endtask

  // Stream 4 bundles; stall out_ready for 3 cycles once the first result shows.
  // Bundle j, lane i: a = 10j+i+1, b = 3, a_sign = j odd.
  task automatic test_backpressure();
    logic [55:0] exp_mag [4];
    logic [3:0]  exp_sign [4];
    logic [55:0] snap_mag;
    logic [3:0]  snap_sign;
    int          sent;
    int          got;
    int          stall_left;
    int          cyc;
    bit          stalled;
    bit          released;
    logic        acc;
    exp_mag[0]  = pk_p(12, 9, 6, 3);
    exp_mag[1]  = pk_p(42, 39, 36, 33);
    exp_mag[2]  = pk_p(72, 69, 66, 63);
    exp_mag[3]  = pk_p(102, 99, 96, 93);
    exp_sign[0] = 4'h0;
    exp_sign[1] = 4'hF;
    exp_sign[2] = 4'h0;
    exp_sign[3] = 4'hF;
    snap_mag    = '0;
    snap_sign   = '0;
    sent        = 0;
    got         = 0;
    stall_left  = 0;
    cyc         = 0;
    stalled     = 1'b0;
    released    = 1'b0;
    while (got < 4 && cyc < 40) begin
      if (out_valid && !stalled) begin
        stalled    = 1'b1;
        stall_left = 3;
        snap_mag   = p_mag;
        snap_sign  = p_sign;
      end
      out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      if (sent < 4) begin
        drive(4'hF, (sent % 2 == 1) ? 4'hF : 4'h0,
              pk_a(10*sent+4, 10*sent+3, 10*sent+2, 10*sent+1), 4'h0, pk_a(3, 3, 3, 3));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_stall_valid: got %b want 1", out_valid); end
        n_cmp++; if (p_mag !== snap_mag) begin n_err++; $display("FAIL bp_stall_mag: got %h want %h", p_mag, snap_mag); end
        n_cmp++; if (p_sign !== snap_sign) begin n_err++; $display("FAIL bp_stall_sign: got %b want %b", p_sign, snap_sign); end
        stall_left--;
        if (stall_left == 0) released = 1'b1;
      end else begin
        if (released) begin
          n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_gap: got out_valid %b want 1 at result %0d", out_valid, got); end
        end
        if (out_valid) begin
          n_cmp++; if (p_mag !== exp_mag[got]) begin n_err++; $display("FAIL bp_mag%0d: got %h want %h", got, p_mag, exp_mag[got]); end
          n_cmp++; if (p_sign !== exp_sign[got]) begin n_err++; $display("FAIL bp_sign%0d: got %b want %b", got, p_sign, exp_sign[got]); end
          got++;
        end
      end
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
      cyc++;
    end
    n_cmp++; if (got !== 4) begin n_err++; $display("FAIL bp_count: got %0d results want 4", got); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_extra: got out_valid %b want 0", out_valid); end
  endtask

  // Reset with two bundles in flight, then confirm nothing stale ever emerges.
  task automatic test_reset_inflight();
    out_ready = 1'b1;
    drive(4'hF, 4'h0, pk_a(5, 5, 5, 5), 4'h0, pk_a(5, 5, 5, 5));
    step();
    drive(4'hF, 4'h0, pk_a(6, 6, 6, 6), 4'h0, pk_a(6, 6, 6, 6));
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", out_valid); end
    n_cmp++; if (p_mag !== 56'h0) begin n_err++; $display("FAIL rst_async_mag: got %h want 0", p_mag); end
    n_cmp++; if (p_sign !== 4'h0) begin n_err++; $display("FAIL rst_async_sign: got %b want 0", p_sign); end
    step();
    reset = 1'b0;
    drive(4'hF, 4'h0, pk_a(7, 7, 7, 7), 4'h0, pk_a(7, 7, 7, 7));
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale: got out_valid %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_first_valid: got %b want 1", out_valid); end
    n_cmp++; if (p_mag !== pk_p(49, 49, 49, 49)) begin n_err++; $display("FAIL rst_first_mag: got %h want %h", p_mag, pk_p(49, 49, 49, 49)); end
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_quiet%0d: got %b want 0", c, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lane_en();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
